seg7_scan_driver: RTL and testbench

Time-multiplexed driver for the board's 4-digit common-anode 7-segment display. It sits downstream of the logic stages (gates, counters), which present a 16-bit hex value. It decodes one nibble per digit and scans the anodes at a fixed refresh rate, with a guard gap against ghosting. New values are applied only at frame boundaries, so a displayed frame never mixes old and new digits.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_scan_driver_if.sv | 29 ++
 rtl/hex_to_seg7.sv | 11 +
 rtl/seg7_scan_driver.sv | 107 ++++++++++
 tb/tb_seg7_scan_driver.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, types and decode table for the 7-segment scan driver
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef logic [1:0] digit_idx_t;

    // Active-low g..a patterns, entry 15 first so that SEG_DECODE[n] is the glyph for n.
    localparam logic [15:0][6:0] SEG_DECODE = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    // Digit k (k = 3..1) blanks when it and every more-significant nibble are zero.
    function automatic logic [3:0] lz_blank_mask(input logic [15:0] value);
        logic [3:0] mask;
        mask[3] = (value[15:12] == 4'h0);
        mask[2] = mask[3] && (value[11:8] == 4'h0);
        mask[1] = mask[2] && (value[7:4] == 4'h0);
        mask[0] = 1'b0;
        return mask;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - load/data bus and display outputs of the scan driver
interface seg7_scan_driver_if;

    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dig_en;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    modport master (
        output load,
        output data_in,
        output dig_en,
        input  seg,
        input  an,
        input  frame_done
    );

    modport slave (
        input  load,
        input  data_in,
        input  dig_en,
        output seg,
        output an,
        output frame_done
    );

endinterface

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational nibble to active-low g..a segment pattern
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_DECODE[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit common-anode scan driver with frame-aligned updates
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIV   = 100000,
    parameter int GUARD = 16
)
(
    input  logic                clk,
    input  logic                rst_n,
    seg7_scan_driver_if.slave   io_bus
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [TW-1:0] GUARD_T   = TW'(GUARD);

    logic [TW-1:0] r_tick;
    digit_idx_t    r_idx;
    logic          r_pend;
    logic [15:0]   r_pend_data;
    logic [3:0]    r_pend_en;
    logic [15:0]   r_disp_data;
    logic [3:0]    r_disp_en;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;
    logic          r_frame_done;

    logic          w_slot_end;
    logic          w_boundary;
    logic          w_in_guard;
    logic [3:0]    w_lz_blank;
    logic [3:0]    w_nibble;
    logic [6:0]    w_dec_seg;
    logic          w_show;

    assign w_slot_end = (r_tick == TICK_LAST);
    assign w_boundary = w_slot_end && (r_idx == 2'd3);
    assign w_in_guard = (r_tick < GUARD_T);

`ifdef SEG7_LZ_BLANK_EN
    assign w_lz_blank = lz_blank_mask(r_disp_data);
`else
    assign w_lz_blank = 4'b0000;
`endif

    assign w_nibble = r_disp_data[{r_idx, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .i_nibble (w_nibble),
        .o_seg    (w_dec_seg)
    );

    assign w_show = !w_in_guard && r_disp_en[r_idx] && !w_lz_blank[r_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick       <= '0;
            r_idx        <= '0;
            r_pend       <= 1'b0;
            r_pend_data  <= '0;
            r_pend_en    <= '0;
            r_disp_data  <= '0;
            r_disp_en    <= '0;
            r_seg        <= SEG_BLANK;
            r_an         <= AN_OFF;
            r_frame_done <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_tick <= '0;
                r_idx  <= r_idx + 2'd1;
            end else begin
                r_tick <= r_tick + 1'b1;
            end

            // The copy sees pre-edge pending contents, so a load on the boundary waits a frame.
            if (w_boundary && r_pend) begin
                r_disp_data <= r_pend_data;
                r_disp_en   <= r_pend_en;
            end

            if (io_bus.load) begin
                r_pend_data <= io_bus.data_in;
                r_pend_en   <= io_bus.dig_en;
                r_pend      <= 1'b1;
            end else if (w_boundary) begin
                r_pend      <= 1'b0;
            end

            r_frame_done <= w_boundary;

            if (w_show) begin
                r_an  <= ~(4'b0001 << r_idx);
                r_seg <= w_dec_seg;
            end else begin
                r_an  <= AN_OFF;
                r_seg <= SEG_BLANK;
            end
        end
    end

    assign io_bus.seg        = r_seg;
    assign io_bus.an         = r_an;
    assign io_bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver with DIV=8, GUARD=2
module tb_seg7_scan_driver;

    localparam int DIV   = 8;
    localparam int GUARD = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_driver_if bus();

    seg7_scan_driver #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    exp_t expect_q[$];
    exp_t mon_e;
    int   checks     = 0;
    int   errors     = 0;
    int   act_cnt    = 0;
    int   act_before = 0;
    int   cyc        = 0;
    int   last_fd    = 0;
    bit   have_last  = 0;
    int   run_len    = 0;
    int   gap_len    = 0;
    logic prev_fd    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every lit cycle must match the next queued expectation; blank cycles must be fully dark.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
            gap_len = 0;
            prev_fd = 1'b0;
        end else begin
            if (bus.frame_done) begin
                checks++;
                if (prev_fd) begin
                    errors++;
                    $display("FAIL frame_done_width: high for 2 consecutive cycles, required 1");
                end
            end
            prev_fd = bus.frame_done;
            if (bus.an != 4'hF) begin
                act_cnt++;
                if (run_len == 0 && gap_len > 0 && gap_len < DIV) begin
                    checks++;
                    if (gap_len != GUARD) begin
                        errors++;
                        $display("FAIL guard_gap: got %0d dark cycles, required %0d", gap_len, GUARD);
                    end
                end
                checks++;
                if (expect_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_digit: got an=%b seg=%b, required nothing lit", bus.an, bus.seg);
                end else begin
                    mon_e = expect_q.pop_front();
                    if ({bus.an, bus.seg} !== {mon_e.an, mon_e.seg}) begin
                        errors++;
                        $display("FAIL digit: got an=%b seg=%b, required an=%b seg=%b",
                                 bus.an, bus.seg, mon_e.an, mon_e.seg);
                    end
                end
                run_len++;
                gap_len = 0;
            end else begin
                checks++;
                if (bus.seg !== 7'h7F) begin
                    errors++;
                    $display("FAIL blank_seg: got seg=%b with anodes off, required 1111111", bus.seg);
                end
                if (run_len > 0) begin
                    checks++;
                    if (run_len != DIV - GUARD) begin
                        errors++;
                        $display("FAIL on_time: got %0d lit cycles, required %0d", run_len, DIV - GUARD);
                    end
                end
                run_len = 0;
                gap_len++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] m);
        bus.load    = 1'b1;
        bus.data_in = d;
        bus.dig_en  = m;
        @(posedge clk);
        #1;
        bus.load    = 1'b0;
    endtask

    task automatic note_frame();
        if (have_last) begin
            checks++;
            if (cyc - last_fd != 4 * DIV) begin
                errors++;
                $display("FAIL frame_period: got %0d cycles, required %0d", cyc - last_fd, 4 * DIV);
            end
        end
        last_fd   = cyc;
        have_last = 1'b1;
    endtask

    task automatic wait_frame();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk);
            #1;
            if (bus.frame_done) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL frame_timeout: got no frame_done in 40 cycles, required one");
        end else begin
            note_frame();
        end
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] show);
        logic [6:0] s [4];
        exp_t       e;
        s[0] = s0;
        s[1] = s1;
        s[2] = s2;
        s[3] = s3;
        for (int k = 0; k < 4; k++) begin
            if (show[k]) begin
                for (int j = 0; j < DIV - GUARD; j++) begin
                    e.an  = ~(4'b0001 << k);
                    e.seg = s[k];
                    expect_q.push_back(e);
                end
            end
        end
    endtask

    task automatic check_out(input string name);
        checks += 3;
        if (bus.an !== 4'hF) begin
            errors++;
            $display("FAIL %s_an: got %b, required 1111", name, bus.an);
        end
        if (bus.seg !== 7'h7F) begin
            errors++;
            $display("FAIL %s_seg: got %b, required 1111111", name, bus.seg);
        end
        if (bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_frame_done: got %b, required 0", name, bus.frame_done);
        end
    endtask

    initial begin
        bus.load    = 1'b0;
        bus.data_in = 16'h0000;
        bus.dig_en  = 4'h0;
        rst_n       = 1'b0;
        step(3);
        check_out("reset");
        rst_n = 1'b1;
        step(100);
        checks++;
        if (act_cnt != 0) begin
            errors++;
            $display("FAIL idle_dark: got %0d lit cycles, required 0", act_cnt);
        end

        wait_frame();
        do_load(16'h12A0, 4'hF);
        wait_frame();
        push_frame(7'h40, 7'h08, 7'h24, 7'h79, 4'hF);

        step(9);
        do_load(16'hFFFF, 4'hF);
        wait_frame();
        push_frame(7'h0E, 7'h0E, 7'h0E, 7'h0E, 4'hF);

        do_load(16'hBCDE, 4'hF);
        step(30);
        do_load(16'h0005, 4'hF);
        checks++;
        if (!bus.frame_done) begin
            errors++;
            $display("FAIL boundary_frame_done: got 0, required 1");
        end else begin
            note_frame();
        end
        push_frame(7'h06, 7'h21, 7'h46, 7'h03, 4'hF);
        wait_frame();
`ifdef SEG7_LZ_BLANK_EN
        push_frame(7'h12, 7'h40, 7'h40, 7'h40, 4'b0001);
`else
        push_frame(7'h12, 7'h40, 7'h40, 7'h40, 4'hF);
`endif

        do_load(16'h0000, 4'b0101);
        wait_frame();
`ifdef SEG7_LZ_BLANK_EN
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0001);
`else
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0101);
`endif

        do_load(16'h0030, 4'hF);
        wait_frame();
`ifdef SEG7_LZ_BLANK_EN
        push_frame(7'h40, 7'h30, 7'h40, 7'h40, 4'b0011);
`else
        push_frame(7'h40, 7'h30, 7'h40, 7'h40, 4'hF);
`endif

        do_load(16'h1111, 4'hF);
        step(18);
        rst_n = 1'b0;
        #1;
        check_out("reset_async");
        expect_q.delete();
        have_last = 1'b0;
        step(2);
        rst_n = 1'b1;
        act_before = act_cnt;
        step(100);
        checks++;
        if (act_cnt != act_before) begin
            errors++;
            $display("FAIL post_reset_dark: got %0d lit cycles, required 0", act_cnt - act_before);
        end

        do_load(16'h9C6D, 4'hF);
        wait_frame();
        push_frame(7'h21, 7'h02, 7'h46, 7'h10, 4'hF);
        do_load(16'h0000, 4'h0);
        wait_frame();
        step(40);
        checks++;
        if (expect_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unseen expected cycles, required 0", expect_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
